karatsuba_combine: RTL
======================

Name: karatsuba_combine

Overview:
- Karatsuba recombination stage, directly downstream of three `mul32_80` instances.
- Those instances produce z0 = aL*bL, z2 = aH*bH and z1 = (aL+aH)*(bL+bH) for one full-width operand pair.
- This block forms mid = z1 - z0 - z2 and the full product {z2,z0} + (mid << H).
- Fixed-latency, 2-cycle pipeline with valid/tag tracking and no backpressure. Upstream multipliers cannot stall, so neither can this block.

Parameters:
- WIDTH, 64, full operand width; even, range [64, 160]; H = WIDTH/2 is the half width, range [32, 80].
- TAG_W, 8, width of the sideband tag carried alongside each product.
- CPA_THRES, 80, THRES value passed to both `addcpred` instances.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  z0/z1/z2/in_tag are valid this cycle.
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
- z0  input  2*H  low-half product.
- z2  input  2*H  high-half product.
- z1  input  2*H+2  sum-operand product.
- out_valid  output  1  c/out_tag/out_err are valid.
- out_tag  output  TAG_W  tag of the result.
- c  output  2*WIDTH  full product.
- out_err  output  1  inconsistent inputs (z1 < z0 + z2).

Behaviour:
- Reset (rst high at a clock edge): out_valid=0, out_err=0, c=0, out_tag=0, and all internal valid bits cleared. Reset dominates in_valid in the same cycle.
- Latency: item accepted at edge n (in_valid=1) appears with out_valid=1 after edge n+2. One item per cycle throughput.
- Bubbles: in_valid=0 propagates as out_valid=0 two cycles later. While out_valid=0, c/out_tag/out_err hold their previous values. Data registers load only when their stage valid is 1.
- Stage 1 (edge n):
  - Zero-extend z0 and z2 to 2H+3 bits.
  - Compute diff = z1 + ~z0 + ~z2 + 2 in 2H+3 bits, using one `add3to2` level plus `addcpred`.
  - err1 = (z0 + z2 > z1), equivalent to the sign bit of diff.
  - mid = diff[2H+1:0].
  - Register mid, z0, z2, err1, tag, v1.
- Stage 2 (edge n+1):
  - lo = {z2, z0}, width 4H (plain concatenation, no adder).
  - sum = lo + (mid << H), computed mod 2^(2*WIDTH) with `addcpred`. For consistent inputs no overflow is possible.
  - If err1=1: c <= 0 and out_err <= 1. Otherwise c <= sum and out_err <= 0.
  - out_tag <= tag, out_valid <= v1.
- Widths: mid needs at most 2H+1 significant bits for consistent inputs. Bit 2H+1 set while err1=0 is impossible; the bench checks it.
- Reset mid-operation: in-flight items are discarded, with no out_valid for them. Items presented in the cycle after rst deasserts are processed normally.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package `karatsuba_pkg`:
  - localparam function half_w(WIDTH) = WIDTH/2.
  - Width helpers: prod_w(H) = 2H, sum_prod_w(H) = 2H+2.
  - typedef struct for the stage-1 register bundle {v, err, tag, mid, z0, z2}, parameterised via the package's width constants.
- Natural sub-module: `karatsuba_mid_sub`, the combinational z1 - z0 - z2 with borrow flag, built from `add3to2` and `addcpred`. It is reused by the wider Karatsuba levels.
- Top-level: instantiates `karatsuba_mid_sub` and the stage-2 `addcpred`, plus the pipeline registers.

Test Plan:
- a=b=0xFFFF_FFFF_FFFF_FFFF, WIDTH=64: z0=z2=0xFFFFFFFE_00000001, z1=0x3_FFFFFFF8_00000004, tag=0x11 -> two cycles later out_valid=1, c=0xFFFFFFFF_FFFFFFFE_00000000_00000001, out_tag=0x11, out_err=0.
- a=b=0x1_00000001: z0=1, z2=1, z1=4 -> c=0x1_00000002_00000001, out_err=0.
- Inconsistent inputs z0=5, z2=5, z1=3 -> out_valid=1, out_err=1, c=0. A following valid item returns out_err=0.
- in_valid pattern 1,0,1,1 with tags 3,–,7,9 -> out_valid 1,0,1,1 offset by 2 cycles, tags 3,7,9. c holds its value during the bubble.
- Item accepted at cycle n, rst=1 at cycle n+1 -> out_valid stays 0 and c=0. A new item at the first cycle after rst deasserts emerges 2 cycles later.
- Integration: three `mul32_80` (WIDTH=33 for sums, 32 for halves) feeding this block, with 10k random 64-bit pairs and in_valid delayed 2 cycles -> c equals the a*b reference model at total latency 4; out_err is never set.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// Shared width helpers and the default-width stage-1 register bundle for the
// Karatsuba recombination levels.
package karatsuba_pkg;

  localparam int KC_WIDTH_DEF = 64;
  localparam int KC_TAG_W_DEF = 8;

  function automatic int half_w(input int width);
    return width / 2;
  endfunction

  function automatic int prod_w(input int h);
    return 2 * h;
  endfunction

  function automatic int sum_prod_w(input int h);
    return 2 * h + 2;
  endfunction

  localparam int KC_H_DEF  = half_w(KC_WIDTH_DEF);
  localparam int KC_PW_DEF = prod_w(KC_H_DEF);
  localparam int KC_SW_DEF = sum_prod_w(KC_H_DEF);

  typedef struct packed {
    logic                    v;
    logic                    err;
    logic [KC_TAG_W_DEF-1:0] tag;
    logic [KC_SW_DEF-1:0]    mid;
    logic [KC_PW_DEF-1:0]    z0;
    logic [KC_PW_DEF-1:0]    z2;
  } kc_s1_t;

endpackage

// File: rtl/add3to2.sv
// Carry-save 3:2 compressor; ci fills the vacated LSB of the shifted carry vector.
module add3to2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);

  assign s  = a ^ b ^ c;
  assign cy = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), ci};

endmodule

// File: rtl/addcpred.sv
// Carry-propagate adder, result mod 2^W. Above THRES bits the upper part is
// computed for both incoming carries and selected by the lower carry.
module addcpred #(
  parameter int W     = 64,
  parameter int THRES = 80
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s
);

  if (W <= THRES) begin : g_flat
    assign s = a + b + W'(cin);
  end else begin : g_split
    localparam int HW = W - THRES;
    logic [THRES:0]  lo;
    logic [HW-1:0]   hi0;
    logic [HW-1:0]   hi1;

    assign lo  = {1'b0, a[THRES-1:0]} + {1'b0, b[THRES-1:0]} + (THRES+1)'(cin);
    assign hi0 = a[W-1:THRES] + b[W-1:THRES];
    assign hi1 = hi0 + HW'(1);
    assign s   = {lo[THRES] ? hi1 : hi0, lo[THRES-1:0]};
  end

endmodule

// File: rtl/karatsuba_mid_sub.sv
// Combinational mid = z1 - z0 - z2 with a borrow flag that is set when z0 + z2 > z1.
module karatsuba_mid_sub #(
  parameter int H         = 32,
  parameter int CPA_THRES = 80
) (
  input  logic [2*H-1:0] z0,
  input  logic [2*H-1:0] z2,
  input  logic [2*H+1:0] z1,
  output logic [2*H+1:0] mid,
  output logic           borrow
);

  localparam int DW = 2 * H + 3;

  logic [DW-1:0] z1_e;
  logic [DW-1:0] z0_n;
  logic [DW-1:0] z2_n;
  logic [DW-1:0] s;
  logic [DW-1:0] cy;
  logic [DW-1:0] diff;

  assign z1_e = {1'b0, z1};
  assign z0_n = ~{3'b000, z0};
  assign z2_n = ~{3'b000, z2};

  // The two +1s that complete both two's complements enter via ci and cin.
  add3to2 #(.W(DW)) u_csa (
    .a  (z1_e),
    .b  (z0_n),
    .c  (z2_n),
    .ci (1'b1),
    .s  (s),
    .cy (cy)
  );

  addcpred #(.W(DW), .THRES(CPA_THRES)) u_cpa (
    .a   (s),
    .b   (cy),
    .cin (1'b1),
    .s   (diff)
  );

  assign mid    = diff[2*H+1:0];
  assign borrow = diff[DW-1];

endmodule

// File: rtl/karatsuba_combine.sv
// Karatsuba recombination: c = {z2,z0} + ((z1 - z0 - z2) << H), two-stage pipeline.
module karatsuba_combine
  import karatsuba_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int TAG_W     = 8,
  parameter int CPA_THRES = 80
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [TAG_W-1:0]                 in_tag,
  input  logic [prod_w(half_w(WIDTH))-1:0] z0,
  input  logic [prod_w(half_w(WIDTH))-1:0] z2,
  input  logic [sum_prod_w(half_w(WIDTH))-1:0] z1,
  output logic                             out_valid,
  output logic [TAG_W-1:0]                 out_tag,
  output logic [2*WIDTH-1:0]               c,
  output logic                             out_err
);

  localparam int H  = half_w(WIDTH);
  localparam int PW = prod_w(H);
  localparam int SW = sum_prod_w(H);
  localparam int CW = 2 * WIDTH;

  typedef struct packed {
    logic             v;
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [SW-1:0]    mid;
    logic [PW-1:0]    z0;
    logic [PW-1:0]    z2;
  } s1_t;

  // Handshake: valid-only, no ready. An item is taken on every edge where
  // in_valid=1 and leaves with out_valid=1 two edges later; nothing can stall.
  s1_t           s1;
  logic [SW-1:0] mid_c;
  logic          err_c;
  logic [CW-1:0] lo;
  logic [CW-1:0] mid_sh;
  logic [CW-1:0] sum;

  karatsuba_mid_sub #(.H(H), .CPA_THRES(CPA_THRES)) u_mid (
    .z0     (z0),
    .z2     (z2),
    .z1     (z1),
    .mid    (mid_c),
    .borrow (err_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.v <= in_valid;
      if (in_valid) begin
        s1.err <= err_c;
        s1.tag <= in_tag;
        s1.mid <= mid_c;
        s1.z0  <= z0;
        s1.z2  <= z2;
      end
    end
  end

  assign lo     = {s1.z2, s1.z0};
  assign mid_sh = CW'(s1.mid) << H;

  addcpred #(.W(CW), .THRES(CPA_THRES)) u_final (
    .a   (lo),
    .b   (mid_sh),
    .cin (1'b0),
    .s   (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      c         <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= s1.v;
      if (s1.v) begin
        out_tag <= s1.tag;
        if (s1.err) begin
          c       <= '0;
          out_err <= 1'b1;
        end else begin
          c       <= sum;
          out_err <= 1'b0;
        end
      end
    end
  end

endmodule
